// File: rtl/itcm_arb_ctrl.sv
// itcm_arb_ctrl: arbitrates IFU (and optional LSU) commands onto a single-port ITCM RAM with in-order buffered responses
// Optional feature macro: ITCM_LSU_PORT_EN adds the LSU port and round-robin arbitration.
// Ports:
//   clk, rst_n                       core clock, asynchronous active-low reset
//   ifu_cmd_* / ifu_rsp_*            IFU command (valid/ready, read, addr, wmask, wdata) and response (valid/ready, rdata)
//   lsu_cmd_* / lsu_rsp_*            LSU port, same shape as IFU (ITCM_LSU_PORT_EN only)
//   ram_cs, ram_we, ram_addr,
//   ram_wem, ram_din, ram_dout       single-port synchronous RAM, one-cycle read latency
`ifndef ITCM_RAM_AW
`define ITCM_RAM_AW 12
`endif
`ifndef ITCM_RAM_DW
`define ITCM_RAM_DW 32
`endif
module itcm_arb_ctrl #(
   parameter int AW = `ITCM_RAM_AW,
   parameter int DW = `ITCM_RAM_DW,
   parameter int MW = DW/8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ifu_cmd_valid,
   output logic          ifu_cmd_ready,
   input  logic          ifu_cmd_read,
   input  logic [AW-1:0] ifu_cmd_addr,
   input  logic [MW-1:0] ifu_cmd_wmask,
   input  logic [DW-1:0] ifu_cmd_wdata,
   output logic          ifu_rsp_valid,
   input  logic          ifu_rsp_ready,
   output logic [DW-1:0] ifu_rsp_rdata,
`ifdef ITCM_LSU_PORT_EN
   input  logic          lsu_cmd_valid,
   output logic          lsu_cmd_ready,
   input  logic          lsu_cmd_read,
   input  logic [AW-1:0] lsu_cmd_addr,
   input  logic [MW-1:0] lsu_cmd_wmask,
   input  logic [DW-1:0] lsu_cmd_wdata,
   output logic          lsu_rsp_valid,
   input  logic          lsu_rsp_ready,
   output logic [DW-1:0] lsu_rsp_rdata,
`endif
   output logic          ram_cs,
   output logic          ram_we,
   output logic [AW-1:0] ram_addr,
   output logic [MW-1:0] ram_wem,
   output logic [DW-1:0] ram_din,
   input  logic [DW-1:0] ram_dout
);
   logic          issue, credit, rsp_pop, head_vld, sel_rd;
   logic [AW-1:0] sel_addr;
   logic [MW-1:0] sel_wmask;
   logic [DW-1:0] sel_wdata, head_data;
   logic          s1_vld, s1_rd, wr_ptr, rd_ptr;
   logic [1:0]    fifo_cnt;
   logic [DW-1:0] fifo_data [2];

   assign head_vld  = fifo_cnt != 2'd0;
   assign head_data = fifo_data[rd_ptr];
   // Every access in s1 or the FIFO owns a slot; a pop this cycle frees one in time for the new issue.
   // Gated by rst_n so nothing reaches the RAM while reset is held.
   assign credit = rst_n & (({1'b0, fifo_cnt} + {2'b0, s1_vld}) < (3'd2 + {2'b0, rsp_pop}));

`ifdef ITCM_LSU_PORT_EN
   logic grant_lsu, last_grant, head_src, s1_src;
   logic fifo_src [2];
   // last_grant=1 means LSU was granted last, so the IFU wins the next contention
   assign grant_lsu     = lsu_cmd_valid & (~ifu_cmd_valid | ~last_grant);
   assign sel_rd        = grant_lsu ? lsu_cmd_read  : ifu_cmd_read;
   assign sel_addr      = grant_lsu ? lsu_cmd_addr  : ifu_cmd_addr;
   assign sel_wmask     = grant_lsu ? lsu_cmd_wmask : ifu_cmd_wmask;
   assign sel_wdata     = grant_lsu ? lsu_cmd_wdata : ifu_cmd_wdata;
   assign issue         = credit & (ifu_cmd_valid | lsu_cmd_valid);
   assign ifu_cmd_ready = credit & ifu_cmd_valid & ~grant_lsu;
   assign lsu_cmd_ready = credit & grant_lsu;
   assign head_src      = fifo_src[rd_ptr];
   assign ifu_rsp_valid = head_vld & ~head_src;
   assign lsu_rsp_valid = head_vld & head_src;
   assign lsu_rsp_rdata = lsu_rsp_valid ? head_data : '0;
   assign rsp_pop       = head_vld & (head_src ? lsu_rsp_ready : ifu_rsp_ready);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         last_grant  <= 1'b1;
         s1_src      <= 1'b0;
         fifo_src[0] <= 1'b0;
         fifo_src[1] <= 1'b0;
      end else begin
         if (issue) last_grant <= grant_lsu;
         s1_src <= grant_lsu;
         if (s1_vld) fifo_src[wr_ptr] <= s1_src;
      end
`else
   assign sel_rd        = ifu_cmd_read;
   assign sel_addr      = ifu_cmd_addr;
   assign sel_wmask     = ifu_cmd_wmask;
   assign sel_wdata     = ifu_cmd_wdata;
   assign issue         = credit & ifu_cmd_valid;
   assign ifu_cmd_ready = credit;
   assign ifu_rsp_valid = head_vld;
   assign rsp_pop       = head_vld & ifu_rsp_ready;
`endif

   assign ifu_rsp_rdata = ifu_rsp_valid ? head_data : '0;
   assign ram_cs        = issue;
   assign ram_we        = issue & ~sel_rd;
   assign ram_addr      = sel_addr;
   assign ram_wem       = (issue & ~sel_rd) ? sel_wmask : '0;
   assign ram_din       = sel_wdata;

   // s1 is always pushed the cycle after issue; the credit rule guarantees room.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_vld       <= 1'b0;
         s1_rd        <= 1'b0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_cnt     <= 2'd0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
      end else begin
         s1_vld <= issue;
         s1_rd  <= sel_rd;
         if (s1_vld) begin
            fifo_data[wr_ptr] <= s1_rd ? ram_dout : '0;
            wr_ptr            <= ~wr_ptr;
         end
         if (rsp_pop) rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, s1_vld} - {1'b0, rsp_pop};
      end
endmodule

// File: tb/tb_itcm_arb_ctrl.sv
// tb_itcm_arb_ctrl: directed self-checking bench for itcm_arb_ctrl with a behavioural RAM
`timescale 1ns/1ps
module tb_itcm_arb_ctrl;
   localparam int AW = 8, DW = 32, MW = 4;
   logic          clk = 1'b0, rst_n = 1'b0;
   logic          ifu_cmd_valid, ifu_cmd_ready, ifu_cmd_read;
   logic [AW-1:0] ifu_cmd_addr;
   logic [MW-1:0] ifu_cmd_wmask;
   logic [DW-1:0] ifu_cmd_wdata;
   logic          ifu_rsp_valid, ifu_rsp_ready;
   logic [DW-1:0] ifu_rsp_rdata;
`ifdef ITCM_LSU_PORT_EN
   logic          lsu_cmd_valid, lsu_cmd_ready, lsu_cmd_read;
   logic [AW-1:0] lsu_cmd_addr;
   logic [MW-1:0] lsu_cmd_wmask;
   logic [DW-1:0] lsu_cmd_wdata;
   logic          lsu_rsp_valid, lsu_rsp_ready;
   logic [DW-1:0] lsu_rsp_rdata;
`endif
   logic          ram_cs, ram_we;
   logic [AW-1:0] ram_addr;
   logic [MW-1:0] ram_wem;
   logic [DW-1:0] ram_din, ram_dout = '0;
   logic [DW-1:0] mem [256];
   int n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   itcm_arb_ctrl #(.AW(AW), .DW(DW), .MW(MW)) dut (
      .clk(clk), .rst_n(rst_n),
      .ifu_cmd_valid(ifu_cmd_valid), .ifu_cmd_ready(ifu_cmd_ready), .ifu_cmd_read(ifu_cmd_read),
      .ifu_cmd_addr(ifu_cmd_addr), .ifu_cmd_wmask(ifu_cmd_wmask), .ifu_cmd_wdata(ifu_cmd_wdata),
      .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_rdata(ifu_rsp_rdata),
`ifdef ITCM_LSU_PORT_EN
      .lsu_cmd_valid(lsu_cmd_valid), .lsu_cmd_ready(lsu_cmd_ready), .lsu_cmd_read(lsu_cmd_read),
      .lsu_cmd_addr(lsu_cmd_addr), .lsu_cmd_wmask(lsu_cmd_wmask), .lsu_cmd_wdata(lsu_cmd_wdata),
      .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_rdata(lsu_rsp_rdata),
`endif
      .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
      .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always @(posedge clk)
      if (ram_cs) begin
         if (ram_we) begin
            for (int b = 0; b < MW; b++) if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
         end else ram_dout <= mem[ram_addr];
      end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One IFU access issued alone; response checked at N+2 and popped the cycle after.
   task automatic ifu_op(input string tag, input logic rd, input logic [7:0] a, input logic [3:0] m,
                         input logic [31:0] d, input logic [31:0] exp);
      @(negedge clk);
      ifu_cmd_valid = 1'b1; ifu_cmd_read = rd; ifu_cmd_addr = a; ifu_cmd_wmask = m; ifu_cmd_wdata = d;
      #1;
      chk({tag, "_rdy"}, 32'(ifu_cmd_ready), 32'd1);
      chk({tag, "_cs"}, 32'(ram_cs), 32'd1);
      chk({tag, "_we"}, 32'(ram_we), 32'(!rd));
      chk({tag, "_wem"}, 32'(ram_wem), rd ? 32'd0 : 32'(m));
      @(negedge clk);
      ifu_cmd_valid = 1'b0;
      #1;
      chk({tag, "_n1_vld"}, 32'(ifu_rsp_valid), 32'd0);
      chk({tag, "_idle_cs"}, 32'(ram_cs), 32'd0);
      @(negedge clk);
      chk({tag, "_vld"}, 32'(ifu_rsp_valid), 32'd1);
      chk({tag, "_data"}, ifu_rsp_rdata, exp);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, r, stall, nr, first, last;
      ifu_cmd_valid = 1'b0; ifu_cmd_read = 1'b1; ifu_cmd_addr = '0; ifu_cmd_wmask = '0; ifu_cmd_wdata = '0;
      ifu_rsp_ready = 1'b1;
`ifdef ITCM_LSU_PORT_EN
      lsu_cmd_valid = 1'b0; lsu_cmd_read = 1'b1; lsu_cmd_addr = 8'h51; lsu_cmd_wmask = '0; lsu_cmd_wdata = '0;
      lsu_rsp_ready = 1'b1;
`endif
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h10] = 32'hDEADBEEF;
      mem[8'h20] = 32'hAAAAAAAA;
      mem[8'h50] = 32'h1F1F0050;
      mem[8'h51] = 32'h2E2E0051;
      for (int i = 0; i < 6; i++) mem[8'h30 + i] = 32'hC0DE0000 + i;
      for (int i = 0; i < 8; i++) mem[8'h40 + i] = 32'h5A5A0000 + i;

      repeat (3) @(negedge clk);
      chk("rst_vld", 32'(ifu_rsp_valid), 32'd0);
      chk("rst_data", ifu_rsp_rdata, 32'd0);
      chk("rst_cs", 32'(ram_cs), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      rst_n = 1'b1;

`ifdef ITCM_LSU_PORT_EN
      ifu_cmd_addr = 8'h50;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("ct_ifu_vld", 32'(ifu_rsp_valid), 32'(c >= 2 && c % 2 == 0));
         chk("ct_lsu_vld", 32'(lsu_rsp_valid), 32'(c >= 2 && c % 2 == 1));
         if (c >= 2) chk("ct_data", (c % 2 == 0) ? ifu_rsp_rdata : lsu_rsp_rdata,
                         (c % 2 == 0) ? 32'h1F1F0050 : 32'h2E2E0051);
         ifu_cmd_valid = c < 4; lsu_cmd_valid = c < 4;
         #1;
         if (c < 4) begin
            chk("ct_ifu_rdy", 32'(ifu_cmd_ready), 32'(c % 2 == 0));
            chk("ct_lsu_rdy", 32'(lsu_cmd_ready), 32'(c % 2 == 1));
         end
      end
`endif

      ifu_op("rd10", 1'b1, 8'h10, 4'h0, 32'h0, 32'hDEADBEEF);
      ifu_op("wr20", 1'b0, 8'h20, 4'b0011, 32'h11223344, 32'h0);
      ifu_op("rd20", 1'b1, 8'h20, 4'hF, 32'h0, 32'hAAAA3344);

      // backpressure: only two accesses fit while responses are held
      @(negedge clk);
      ifu_rsp_ready = 1'b0;
      k = 0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         ifu_cmd_valid = 1'b1; ifu_cmd_read = 1'b1; ifu_cmd_addr = 8'h30 + k[7:0];
         #1;
         if (ifu_cmd_ready) k++;
      end
      chk("bp_accepted", 32'(k), 32'd2);
      chk("bp_rdy_low", 32'(ifu_cmd_ready), 32'd0);
      chk("bp_head_vld", 32'(ifu_rsp_valid), 32'd1);
      chk("bp_head_data", ifu_rsp_rdata, 32'hC0DE0000);
      ifu_cmd_valid = 1'b0;
      ifu_rsp_ready = 1'b1;
      r = 1; stall = 0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (ifu_rsp_valid) begin
            chk("bp_rsp_data", ifu_rsp_rdata, 32'hC0DE0000 + 32'(r));
            r++;
         end
         if (k < 6) begin
            ifu_cmd_valid = 1'b1; ifu_cmd_addr = 8'h30 + k[7:0];
            #1;
            if (ifu_cmd_ready) k++; else stall++;
         end else ifu_cmd_valid = 1'b0;
      end
      chk("bp_rsp_cnt", 32'(r), 32'd6);
      chk("bp_stalls", 32'(stall), 32'd0);

      // eight back-to-back reads with the consumer always ready
      nr = 0; first = -1; last = -1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (ifu_rsp_valid) begin
            chk("b2b_data", ifu_rsp_rdata, 32'h5A5A0000 + 32'(nr));
            if (first < 0) first = c;
            last = c;
            nr++;
         end
         ifu_cmd_valid = c < 8; ifu_cmd_addr = 8'h40 + 8'(c);
      end
      chk("b2b_cnt", 32'(nr), 32'd8);
      chk("b2b_first", 32'(first), 32'd2);
      chk("b2b_last", 32'(last), 32'd9);

      // reset while the FIFO is full and a command is still offered
      ifu_rsp_ready = 1'b0;
      @(negedge clk);
      ifu_cmd_valid = 1'b1; ifu_cmd_addr = 8'h10;
      @(negedge clk);
      ifu_cmd_addr = 8'h20;
      @(negedge clk);
      #1;
      chk("mr_pre_rdy", 32'(ifu_cmd_ready), 32'd0);
      chk("mr_pre_vld", 32'(ifu_rsp_valid), 32'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mr_vld", 32'(ifu_rsp_valid), 32'd0);
      chk("mr_data", ifu_rsp_rdata, 32'd0);
      chk("mr_cs", 32'(ram_cs), 32'd0);
      chk("mr_we", 32'(ram_we), 32'd0);
      @(negedge clk);
      ifu_cmd_valid = 1'b0;
      rst_n = 1'b1;
      ifu_rsp_ready = 1'b1;
      ifu_op("mr_rd", 1'b1, 8'h20, 4'h0, 32'h0, 32'hAAAA3344);
      @(negedge clk);
      chk("mr_drained", 32'(ifu_rsp_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
